// File: rtl/tunnel_painter_pipe.sv
// Concentric-ring pixel painter: radius from a fixed centre via a pipelined restoring
// square root, then radius and latched animation phase mapped to a 3-bit colour.
module tunnel_painter_pipe #(
    parameter int X_BITS      = 6,
    parameter int Y_BITS      = 6,
    parameter int FRAME_BITS  = 7,
    parameter int CENTER_X    = 32,
    parameter int CENTER_Y    = 32,
    parameter int RING_BITS   = 5,
    parameter int SPEED_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic                  frame_start,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [1:0]            mode,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    output logic                  out_valid,
    output logic [2:0]            rgb
);

    localparam int D   = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 1;
    localparam int D1  = D + 1;
    localparam int R2W = 2 * D;
    localparam int N   = R2W / 2;
    localparam int SQW = 2 * D - 1;
    localparam int RW  = D + 3;
    localparam int RB  = RING_BITS;
    localparam int FEW = SPEED_SHIFT + RING_BITS + FRAME_BITS;

    localparam logic [D:0] CX = D1'(CENTER_X);
    localparam logic [D:0] CY = D1'(CENTER_Y);

    // Only the frame bits that feed the phase are kept; the rest never matter.
    logic [FEW-1:0] f_ext;
    logic [RB-1:0]  fph_in, fph_q, fph_use;
    logic [1:0]     mode_q, mode_use;
    logic           take;

    assign f_ext    = FEW'(frame);
    assign fph_in   = f_ext[SPEED_SHIFT +: RB];
    assign take     = in_valid & frame_start;
    assign fph_use  = take ? fph_in : fph_q;
    assign mode_use = take ? mode : mode_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fph_q  <= '0;
            mode_q <= '0;
        end else if (take) begin
            fph_q  <= fph_in;
            mode_q <= mode;
        end
    end

    logic signed [D:0] dx_c, dy_c;
    logic [D-1:0]      ax, ay;
    logic [2*D-1:0]    sqx_c, sqy_c;

    assign dx_c  = $signed(CX) - $signed(D1'(x));
    assign dy_c  = $signed(CY) - $signed(D1'(y));
    assign ax    = dx_c[D] ? D'(-dx_c) : D'(dx_c);
    assign ay    = dy_c[D] ? D'(-dy_c) : D'(dy_c);
    assign sqx_c = {{D{1'b0}}, ax} * {{D{1'b0}}, ax};
    assign sqy_c = {{D{1'b0}}, ay} * {{D{1'b0}}, ay};

    logic           s1_val, s2_val;
    logic [SQW-1:0] s1_sqx, s1_sqy;
    logic [R2W-1:0] s2_r2;
    logic [RB-1:0]  s1_fph, s2_fph;
    logic [1:0]     s1_mode, s2_mode;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_val  <= 1'b0;
            s1_sqx  <= '0;
            s1_sqy  <= '0;
            s1_fph  <= '0;
            s1_mode <= '0;
            s2_val  <= 1'b0;
            s2_r2   <= '0;
            s2_fph  <= '0;
            s2_mode <= '0;
        end else begin
            s1_val  <= in_valid;
            s1_sqx  <= sqx_c[SQW-1:0];
            s1_sqy  <= sqy_c[SQW-1:0];
            s1_fph  <= fph_use;
            s1_mode <= mode_use;
            s2_val  <= s1_val;
            s2_r2   <= {1'b0, s1_sqx} + {1'b0, s1_sqy};
            s2_fph  <= s1_fph;
            s2_mode <= s1_mode;
        end
    end

    logic           sq_val  [1:N];
    logic [D-1:0]   sq_root [1:N];
    logic [RB-1:0]  sq_fph  [1:N];
    logic [1:0]     sq_mode [1:N];
    logic [D:0]     sq_rem  [1:N-1];
    logic [R2W-1:0] sq_r2   [1:N-1];

    // One root bit per stage, most significant first; the remainder never exceeds D+1 bits.
    for (genvar i = 0; i < N; i++) begin : g_sq
        logic           val_in;
        logic [R2W-1:0] r2_in;
        logic [D:0]     rem_in;
        logic [D-1:0]   root_in;
        logic [RB-1:0]  fph_s;
        logic [1:0]     mode_s;
        logic [RW-1:0]  rem_sh, trial;
        logic           ge;

        if (i == 0) begin : g_first
            assign val_in  = s2_val;
            assign r2_in   = s2_r2;
            assign rem_in  = '0;
            assign root_in = '0;
            assign fph_s   = s2_fph;
            assign mode_s  = s2_mode;
        end else begin : g_mid
            assign val_in  = sq_val[i];
            assign r2_in   = sq_r2[i];
            assign rem_in  = sq_rem[i];
            assign root_in = sq_root[i];
            assign fph_s   = sq_fph[i];
            assign mode_s  = sq_mode[i];
        end

        assign rem_sh = {rem_in, r2_in[R2W-1-2*i -: 2]};
        assign trial  = {1'b0, root_in, 2'b01};
        assign ge     = (rem_sh >= trial);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sq_val[i+1]  <= 1'b0;
                sq_root[i+1] <= '0;
                sq_fph[i+1]  <= '0;
                sq_mode[i+1] <= '0;
            end else begin
                sq_val[i+1]  <= val_in;
                sq_root[i+1] <= {root_in[D-2:0], ge};
                sq_fph[i+1]  <= fph_s;
                sq_mode[i+1] <= mode_s;
            end
        end

        if (i < N - 1) begin : g_carry
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sq_rem[i+1] <= '0;
                    sq_r2[i+1]  <= '0;
                end else begin
                    sq_rem[i+1] <= D1'(ge ? rem_sh - trial : rem_sh);
                    sq_r2[i+1]  <= r2_in;
                end
            end
        end else begin : g_last
            logic unused_r2;
            assign unused_r2 = ^r2_in;
        end
    end

    logic [RB+D-1:0] r_ext;
    logic [RB-1:0]   rl, p;
    logic [2:0]      hue, col;

    always_comb begin
        r_ext = {{RB{1'b0}}, sq_root[N]};
        rl    = r_ext[RB-1:0];
        p     = (sq_mode[N] == 2'd1) ? rl + sq_fph[N] : rl - sq_fph[N];
        hue   = p[RB-1 -: 3];
        case (sq_mode[N])
            2'd0, 2'd1: col = {&p, 1'b0, &p[1:0]};
            2'd2:       col = (hue == 3'b000) ? 3'b001 : hue;
            default:    col = {3{p[RB-1]}};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            rgb       <= 3'b000;
        end else begin
            out_valid <= sq_val[N];
            rgb       <= sq_val[N] ? col : 3'b000;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{f_ext, sqx_c[2*D-1], sqy_c[2*D-1], r_ext};

endmodule

// File: tb/tb_tunnel_painter_pipe.sv
// Directed stimulus with a scoreboard of expected colours and due cycles for tunnel_painter_pipe.
module tb_tunnel_painter_pipe;

    localparam int L = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] frame = '0;
    logic [1:0] mode = '0;
    logic [5:0] x = '0;
    logic [5:0] y = '0;
    logic       out_valid;
    logic [2:0] rgb;

    tunnel_painter_pipe dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .frame       (frame),
        .mode        (mode),
        .x           (x),
        .y           (y),
        .out_valid   (out_valid),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] rgb;
        int         due;
    } exp_t;
    exp_t q[$];

    int lf = 0;
    int lm = 0;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [2:0] model(input int xx, input int yy, input int f, input int m);
        int dx, dy, r, rl, fp, p;
        dx = 32 - xx;
        dy = 32 - yy;
        r  = isqrt(dx * dx + dy * dy);
        rl = r % 32;
        fp = (f >> 2) % 32;
        p  = (m == 1) ? (rl + fp) % 32 : (rl - fp + 32) % 32;
        case (m)
            0, 1:    return {(p == 31), 1'b0, ((p % 4) == 3)};
            2:       return ((p / 4) == 0) ? 3'b001 : 3'(p / 4);
            default: return (p >= 16) ? 3'b111 : 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit fs, input int fr, input int md,
                         input int xx, input int yy);
        exp_t e;
        if (v && fs) begin
            lf = fr;
            lm = md;
        end
        if (v) begin
            e.rgb = model(xx, yy, lf, lm);
            e.due = cyc + L;
            q.push_back(e);
        end
        in_valid    = v;
        frame_start = fs;
        frame       = 7'(fr);
        mode        = 2'(md);
        x           = 6'(xx);
        y           = 6'(yy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("rgb", 32'(rgb), 32'(q[0].rgb));
                check("latency_cycle", 32'(cyc), 32'(q[0].due));
                void'(q.pop_front());
            end
        end else begin
            check("rgb_idle_zero", 32'(rgb), 32'd0);
            if (q.size() > 0 && q[0].due <= cyc) begin
                check("missing_out_valid", 32'(out_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_rgb", 32'(rgb), 32'd0);
        resetn = 1'b1;
        idle(2);

        // centre pixel, then the two named corner cases with the frame-0 latch
        drive(1'b1, 1'b1, 0, 0, 32, 32);
        idle(3);
        drive(1'b1, 1'b0, 0, 0, 63, 32);
        drive(1'b1, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 5, 9);
        idle(12);

        // latched frame/mode must ignore changes without a valid frame_start
        drive(1'b1, 1'b1, 4, 0, 63, 32);
        drive(1'b1, 1'b0, 12, 3, 63, 32);
        drive(1'b0, 1'b1, 99, 2, 10, 10);
        drive(1'b1, 1'b0, 12, 1, 32, 60);
        drive(1'b1, 1'b1, 4, 1, 32, 60);
        drive(1'b1, 1'b1, 0, 2, 32, 37);
        drive(1'b1, 1'b1, 40, 3, 1, 50);
        drive(1'b1, 1'b0, 0, 0, 20, 7);
        drive(1'b1, 1'b1, 127, 2, 63, 63);
        idle(12);

        // full back-to-back sweep; each row relatches frame and mode
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++)
                drive(1'b1, (xx == 0), yy * 2, yy % 4, xx, yy);
        idle(12);

        // reset in the middle of a burst, early and with outputs already flowing
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) begin
                if (i == ((k == 0) ? 5 : 15)) begin
                    resetn = 1'b0;
                    q.delete();
                    lf = 0;
                    lm = 0;
                    #1;
                    check("async_reset_out_valid", 32'(out_valid), 32'd0);
                    check("async_reset_rgb", 32'(rgb), 32'd0);
                    in_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    resetn = 1'b1;
                    break;
                end
                drive(1'b1, (i == 0), 20 + i, 2, i * 3, 63 - i);
            end
            idle(L + 4);
            drive(1'b1, 1'b0, 0, 3, 7, 41);
            drive(1'b1, 1'b1, 64, 1, 50, 2);
            drive(1'b1, 1'b0, 0, 0, 33, 31);
            idle(2);
        end

        for (int i = 0; i < L + 5 && q.size() > 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
